// File: rtl/add_sub_arbiter.sv
// Two-requester round-robin front end sharing one add/sub datapath, one-deep result register.
// Optional macro ADD_SUB_ARB_OVF_EN adds a registered signed-overflow output (resp_overflow).

module add_sub_dp #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // Subtract is a + ~b + 1, so carry-out means "no borrow" (a >= b unsigned).
   always_comb begin
      b_eff = sub ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   end

   assign result = sum[WIDTH-1:0];
   assign carry  = sum[WIDTH];
endmodule

// state | meaning
// EMPTY | result register holds nothing, any granted request is accepted
// FULL  | result register holds a result waiting for resp_ready
module add_sub_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_carry
`ifdef ADD_SUB_ARB_OVF_EN
   ,
   output logic             resp_overflow
`endif
);
   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_nxt;
   logic             last_grant;
   logic             grant;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] op_a, op_b, dp_result;
   logic             op_sub, dp_carry;

   // Grant depends only on valids and last_grant; ready is gated afterwards.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;

      can_accept = (state == EMPTY) || resp_ready;
      accept     = rst_n && can_accept && (req0_valid || req1_valid);
      req0_ready = accept && !grant;
      req1_ready = accept && grant;

      op_a   = grant ? req1_a   : req0_a;
      op_b   = grant ? req1_b   : req0_b;
      op_sub = grant ? req1_sub : req0_sub;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (resp_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   add_sub_dp #(.WIDTH(WIDTH)) u_dp (
      .a      (op_a),
      .b      (op_b),
      .sub    (op_sub),
      .result (dp_result),
      .carry  (dp_carry)
   );

   assign resp_valid = (state == FULL);

`ifdef ADD_SUB_ARB_OVF_EN
   logic b_eff_msb, dp_overflow;

   // Signed overflow: operands agree in sign but the result does not.
   always_comb begin
      b_eff_msb   = op_sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
      dp_overflow = (op_a[WIDTH-1] == b_eff_msb) && (dp_result[WIDTH-1] != op_a[WIDTH-1]);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_result <= '0;
         resp_carry  <= 1'b0;
         resp_id     <= 1'b0;
         last_grant  <= 1'b1;
`ifdef ADD_SUB_ARB_OVF_EN
         resp_overflow <= 1'b0;
`endif
      end else if (accept) begin
         resp_result <= dp_result;
         resp_carry  <= dp_carry;
         resp_id     <= grant;
         last_grant  <= grant;
`ifdef ADD_SUB_ARB_OVF_EN
         resp_overflow <= dp_overflow;
`endif
      end
   end
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed and randomized checks of add_sub_arbiter against a queue-free behavioural model.
// Honours ADD_SUB_ARB_OVF_EN to also check resp_overflow.

module tb_add_sub_arbiter;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sub;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req1_a, req1_b;
   logic         resp_valid, resp_ready, resp_id, resp_carry;
   logic [W-1:0] resp_result;
`ifdef ADD_SUB_ARB_OVF_EN
   logic         resp_overflow;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   logic         m_valid, m_carry, m_id, m_ovf, m_last;
   logic [W-1:0] m_result;

   always #5 clk = ~clk;

   add_sub_arbiter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_sub    (req0_sub),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_sub    (req1_sub),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_carry  (resp_carry)
`ifdef ADD_SUB_ARB_OVF_EN
      ,
      .resp_overflow (resp_overflow)
`endif
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic at integer level: wide signed/unsigned sums.
   function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
      logic signed [W+1:0] full;
      logic        [W:0]   wide;
      if (s) begin
         r    = a - b;
         c    = (a >= b);
         full = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         r    = wide[W-1:0];
         c    = wide[W];
         full = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
      end
      o = (full > $signed({2'b00, 1'b0, {(W-1){1'b1}}})) ||
          (full < -$signed({2'b00, 1'b1, {(W-1){1'b0}}}));
   endfunction

   task automatic model_reset();
      m_valid  = 1'b0;
      m_result = '0;
      m_carry  = 1'b0;
      m_id     = 1'b0;
      m_ovf    = 1'b0;
      m_last   = 1'b1;
   endtask

   task automatic check_resp();
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
         chk("resp_result", resp_result, m_result);
         chk("resp_carry", resp_carry, m_carry);
         chk("resp_id", resp_id, m_id);
`ifdef ADD_SUB_ARB_OVF_EN
         chk("resp_overflow", resp_overflow, m_ovf);
`endif
      end
   endtask

   // Called at a negedge with operands already set; ends at the next negedge.
   task automatic cycle(input logic v0, input logic v1, input logic rr);
      logic         can, acc, g;
      logic [W-1:0] r;
      logic         c, o;
      req0_valid = v0;
      req1_valid = v1;
      resp_ready = rr;
      #1;
      can = !m_valid || rr;
      acc = can && (v0 || v1);
      if (v0 && v1) g = (m_last == 1'b0);
      else          g = v1;
      chk("req0_ready", req0_ready, acc && !g);
      chk("req1_ready", req1_ready, acc && g);
      @(posedge clk);
      #1;
      if (acc) begin
         if (g) calc(req1_a, req1_b, req1_sub, r, c, o);
         else   calc(req0_a, req0_b, req0_sub, r, c, o);
         m_valid  = 1'b1;
         m_result = r;
         m_carry  = c;
         m_ovf    = o;
         m_id     = g;
         m_last   = g;
      end else if (rr) begin
         m_valid = 1'b0;
      end
      check_resp();
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] corners [4];
      corners[0] = '0;
      corners[1] = '1;
      corners[2] = {1'b0, {(W-1){1'b1}}};
      corners[3] = {1'b1, {(W-1){1'b0}}};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [W-1:0] held;
      model_reset();
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", resp_valid, 1'b0);
      chk("rst_result", resp_result, '0);
      chk("rst_carry", resp_carry, 1'b0);
      chk("rst_id", resp_id, 1'b0);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      rst_n = 1'b1;

      // add 5+3 from req0
      req0_a = 64'd5; req0_b = 64'd3; req0_sub = 1'b0;
      cycle(1'b1, 1'b0, 1'b1);
      chk("add_result", resp_result, 64'd8);
      chk("add_id", resp_id, 1'b0);

      // subtract 3-5 from req1
      req1_a = 64'd3; req1_b = 64'd5; req1_sub = 1'b1;
      cycle(1'b0, 1'b1, 1'b1);
      chk("sub_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_carry", resp_carry, 1'b0);
      chk("sub_id", resp_id, 1'b1);

      // signed wrap
      req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_sub = 1'b0;
      cycle(1'b1, 1'b0, 1'b1);
      chk("wrap_result", resp_result, 64'h8000_0000_0000_0000);
      chk("wrap_carry", resp_carry, 1'b0);
`ifdef ADD_SUB_ARB_OVF_EN
      chk("wrap_ovf", resp_overflow, 1'b1);
`endif

      // contention right after reset: ids 0,1,0,1
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req0_a = 64'd100; req0_b = 64'd1; req0_sub = 1'b1;
      req1_a = 64'd200; req1_b = 64'd2; req1_sub = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         chk("rr_id", resp_id, i[0]);
      end

      // backpressure: hold for 3 cycles, then drain and accept together
      held = resp_result;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         chk("bp_hold", resp_result, held);
      end
      cycle(1'b1, 1'b1, 1'b1);

      // reset while a result is pending
      chk("pre_rst_valid", resp_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", resp_valid, 1'b0);
      chk("midrst_ready0", req0_ready, 1'b0);
      chk("midrst_ready1", req1_ready, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b1);
      chk("post_rst_id", resp_id, 1'b0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         req0_a   = pick_operand();
         req0_b   = pick_operand();
         req0_sub = 1'($urandom_range(0, 1));
         req1_a   = pick_operand();
         req1_b   = pick_operand();
         req1_sub = 1'($urandom_range(0, 1));
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
